urv_writeback: RTL and testbench

- Final (W) pipeline stage of the Kamikaze-uRV core.
- Selects the destination-register result from one of four sources: the registered ALU/CSR value, the second half of the two-stage barrel shifter, the multiplier, or data-memory load data.
- Aligns and sign/zero-extends load data, and holds the pipeline with a wait-for-load FSM.
- Drives the register-file write port and a registered bypass copy of the last write, used for hazard forwarding.

---
 rtl/kmkz_defs.sv | 21 ++
 rtl/urv_load_align.sv | 34 +++
 rtl/urv_writeback.sv | 146 ++++++++++++++
 tb/tb_urv_writeback.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/kmkz_defs.sv
// Shared Kamikaze-uRV encodings: rd source select, load funct3 codes and
// writeback FSM states.
package kmkz_defs;

    localparam logic [1:0] RD_SOURCE_ALU     = 2'd0;
    localparam logic [1:0] RD_SOURCE_SHIFTER = 2'd1;
    localparam logic [1:0] RD_SOURCE_MUL     = 2'd2;
    localparam logic [1:0] RD_SOURCE_LOAD    = 2'd3;

    localparam logic [2:0] LDST_B  = 3'b000;
    localparam logic [2:0] LDST_H  = 3'b001;
    localparam logic [2:0] LDST_W  = 3'b010;
    localparam logic [2:0] LDST_BU = 3'b100;
    localparam logic [2:0] LDST_HU = 3'b101;

    typedef enum logic {
        WB_RUN       = 1'b0,
        WB_WAIT_LOAD = 1'b1
    } wb_state_t;

endpackage

// File: rtl/urv_load_align.sv
// Little-endian load alignment: picks the addressed byte/half of a word and
// sign- or zero-extends it according to the load funct3.
module urv_load_align
    import kmkz_defs::*;
(
    input  logic [31:0] data_i,
    input  logic [2:0]  fun_i,
    input  logic [1:0]  addr_i,
    output logic [31:0] result_o
);

    logic [7:0]  lanes [4];
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign lanes[gi] = data_i[8*gi +: 8];
    end

    assign byte_sel = lanes[addr_i];
    // addr_i[0] is deliberately ignored for halfword accesses
    assign half_sel = addr_i[1] ? data_i[31:16] : data_i[15:0];

    always_comb begin
        case (fun_i)
            LDST_B:  result_o = {{24{byte_sel[7]}}, byte_sel};
            LDST_BU: result_o = {24'h0, byte_sel};
            LDST_H:  result_o = {{16{half_sel[15]}}, half_sel};
            LDST_HU: result_o = {16'h0, half_sel};
            default: result_o = data_i;
        endcase
    end

endmodule

// File: rtl/urv_writeback.sv
// W stage of the Kamikaze-uRV core: result select, load alignment with a
// wait-for-load FSM (optional timeout), register-file write and bypass copy.
module urv_writeback
    import kmkz_defs::*;
#(
    parameter int g_with_hw_mul  = 1,
    parameter int g_load_timeout = 0
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        x_valid_i,
    input  logic [4:0]  x_rd_i,
    input  logic        x_rd_write_i,
    input  logic [1:0]  x_rd_source_i,
    input  logic [31:0] x_rd_value_i,
    input  logic [2:0]  x_fun_i,
    input  logic [1:0]  x_dm_addr_i,
    input  logic [31:0] w_shifter_rd_i,
    input  logic [31:0] w_mul_rd_i,
    input  logic [31:0] dm_data_l_i,
    input  logic        dm_load_done_i,
    output logic [4:0]  rf_rd_o,
    output logic [31:0] rf_rd_value_o,
    output logic        rf_rd_write_o,
    output logic        w_stall_req_o,
    output logic [4:0]  w_bypass_rd_o,
    output logic [31:0] w_bypass_rd_value_o,
    output logic        w_bypass_rd_write_o,
    output logic        w_load_fault_o
);

    localparam logic [7:0] c_timeout_last = 8'(g_load_timeout - 1);
    localparam bit         c_timeout_en   = (g_load_timeout != 0);

    wb_state_t   state_q;
    logic [4:0]  rd_q;
    logic        rd_write_q;
    logic [2:0]  fun_q;
    logic [1:0]  addr_q;
    logic [7:0]  cnt_q, cnt_d;
    logic        fault_q;
    logic [4:0]  byp_rd_q;
    logic [31:0] byp_value_q;
    logic        byp_write_q;

    logic        waiting, issue_load, expire, stall_raw, wr_en;
    logic [4:0]  wr_rd;
    logic [31:0] wr_value, load_value, mul_value;

    assign waiting    = (state_q == WB_WAIT_LOAD);
    assign issue_load = x_valid_i && (x_rd_source_i == RD_SOURCE_LOAD);
    assign expire     = c_timeout_en && waiting && !dm_load_done_i && (cnt_q == c_timeout_last);
    assign stall_raw  = waiting ? (!dm_load_done_i && !expire) : (issue_load && !dm_load_done_i);
    assign mul_value  = (g_with_hw_mul != 0) ? w_mul_rd_i : 32'h0;
    assign cnt_d      = cnt_q + 8'd1;

    // While waiting, the captured fields steer alignment: X/W may be frozen but
    // the captured copy is authoritative.
    urv_load_align u_load_align (
        .data_i   (dm_data_l_i),
        .fun_i    (waiting ? fun_q : x_fun_i),
        .addr_i   (waiting ? addr_q : x_dm_addr_i),
        .result_o (load_value)
    );

    always_comb begin
        wr_rd    = x_rd_i;
        wr_en    = 1'b0;
        wr_value = x_rd_value_i;
        if (waiting) begin
            wr_rd    = rd_q;
            wr_en    = rd_write_q && (dm_load_done_i || expire);
            wr_value = dm_load_done_i ? load_value : 32'h0;
        end else begin
            wr_en = x_valid_i && x_rd_write_i && !stall_raw;
            case (x_rd_source_i)
                RD_SOURCE_SHIFTER: wr_value = w_shifter_rd_i;
                RD_SOURCE_MUL:     wr_value = mul_value;
                RD_SOURCE_LOAD:    wr_value = load_value;
                default:           wr_value = x_rd_value_i;
            endcase
        end
    end

    assign rf_rd_o       = wr_rd;
    assign rf_rd_value_o = wr_value;
    assign rf_rd_write_o = rst_n_i && wr_en && (wr_rd != 5'd0);
    assign w_stall_req_o = rst_n_i && stall_raw;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= WB_RUN;
            rd_q       <= '0;
            rd_write_q <= 1'b0;
            fun_q      <= '0;
            addr_q     <= '0;
            cnt_q      <= '0;
            fault_q    <= 1'b0;
        end else begin
            fault_q <= 1'b0;
            case (state_q)
                WB_RUN: begin
                    if (issue_load && !dm_load_done_i) begin
                        state_q    <= WB_WAIT_LOAD;
                        rd_q       <= x_rd_i;
                        rd_write_q <= x_rd_write_i;
                        fun_q      <= x_fun_i;
                        addr_q     <= x_dm_addr_i;
                        cnt_q      <= '0;
                    end
                end
                WB_WAIT_LOAD: begin
                    if (dm_load_done_i) begin
                        state_q <= WB_RUN;
                    end else if (expire) begin
                        state_q <= WB_RUN;
                        fault_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                default: state_q <= WB_RUN;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            byp_rd_q    <= '0;
            byp_value_q <= '0;
            byp_write_q <= 1'b0;
        end else begin
            byp_write_q <= rf_rd_write_o;
            if (rf_rd_write_o) begin
                byp_rd_q    <= rf_rd_o;
                byp_value_q <= rf_rd_value_o;
            end
        end
    end

    assign w_bypass_rd_o       = byp_rd_q;
    assign w_bypass_rd_value_o = byp_value_q;
    assign w_bypass_rd_write_o = byp_write_q;
    assign w_load_fault_o      = fault_q;

endmodule

// File: tb/tb_urv_writeback.sv
// Directed and random checks of urv_writeback against a pending-load model.
module tb_urv_writeback;

    localparam int TIMEOUT = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        x_valid, x_we, done;
    logic [4:0]  x_rd;
    logic [1:0]  x_src;
    logic [31:0] x_val, shf, mul, dm_data;
    logic [2:0]  x_fun;
    logic [1:0]  x_addr;
    logic [4:0]  rf_rd, byp_rd;
    logic [31:0] rf_val, byp_val;
    logic        rf_we, stall, byp_we, fault;

    urv_writeback #(.g_with_hw_mul(1), .g_load_timeout(TIMEOUT)) u_dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .x_valid_i(x_valid), .x_rd_i(x_rd), .x_rd_write_i(x_we),
        .x_rd_source_i(x_src), .x_rd_value_i(x_val), .x_fun_i(x_fun),
        .x_dm_addr_i(x_addr), .w_shifter_rd_i(shf), .w_mul_rd_i(mul),
        .dm_data_l_i(dm_data), .dm_load_done_i(done),
        .rf_rd_o(rf_rd), .rf_rd_value_o(rf_val), .rf_rd_write_o(rf_we),
        .w_stall_req_o(stall), .w_bypass_rd_o(byp_rd),
        .w_bypass_rd_value_o(byp_val), .w_bypass_rd_write_o(byp_we),
        .w_load_fault_o(fault)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Model: a load is either pending (with its captured fields) or not.
    bit          m_pend;
    logic [4:0]  m_rd;
    bit          m_we;
    logic [2:0]  m_fun;
    logic [1:0]  m_addr;
    int          m_waits;
    bit          m_byp_we;
    logic [4:0]  m_byp_rd;
    logic [31:0] m_byp_val;
    bit          m_fault;

    logic        obs_we, obs_stall;
    logic [4:0]  obs_rd;
    logic [31:0] obs_val;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_align(input logic [31:0] d, input logic [2:0] f,
                                              input logic [1:0] a);
        logic [31:0] b, h;
        b = (d >> (8 * a)) & 32'hFF;
        h = (d >> (16 * a[1])) & 32'hFFFF;
        case (f)
            3'd0:    return (b >= 32'd128)   ? b + 32'hFFFF_FF00 : b;
            3'd1:    return (h >= 32'd32768) ? h + 32'hFFFF_0000 : h;
            3'd4:    return b;
            3'd5:    return h;
            default: return d;
        endcase
    endfunction

    task automatic model_reset();
        m_pend = 0; m_waits = 0; m_rd = 0; m_we = 0; m_fun = 0; m_addr = 0;
        m_byp_we = 0; m_byp_rd = 0; m_byp_val = 0; m_fault = 0;
    endtask

    // Called at posedge+1 with inputs already driven; returns at next posedge+1.
    task automatic run_cycle(input string tag);
        bit e_stall, e_we, n_fault;
        logic [4:0] e_rd;
        logic [31:0] e_val;
        e_stall = 0; e_we = 0; e_rd = 0; e_val = 0; n_fault = 0;
        #1;
        obs_we = rf_we; obs_stall = stall; obs_rd = rf_rd; obs_val = rf_val;
        if (!m_pend) begin
            if (x_valid && x_src == 2'd3 && !done) begin
                e_stall = 1;
                m_pend = 1; m_waits = 0;
                m_rd = x_rd; m_we = x_we; m_fun = x_fun; m_addr = x_addr;
            end else if (x_valid) begin
                e_we = x_we && (x_rd != 0);
                e_rd = x_rd;
                case (x_src)
                    2'd0: e_val = x_val;
                    2'd1: e_val = shf;
                    2'd2: e_val = mul;
                    default: e_val = ref_align(dm_data, x_fun, x_addr);
                endcase
            end
        end else if (done) begin
            e_we = m_we && (m_rd != 0); e_rd = m_rd;
            e_val = ref_align(dm_data, m_fun, m_addr);
            m_pend = 0;
        end else if (m_waits + 1 == TIMEOUT) begin
            e_we = m_we && (m_rd != 0); e_rd = m_rd; e_val = 32'h0;
            n_fault = 1; m_pend = 0;
        end else begin
            e_stall = 1; m_waits++;
        end
        chk({tag, ".stall"}, {31'h0, obs_stall}, {31'h0, e_stall});
        chk({tag, ".we"}, {31'h0, obs_we}, {31'h0, e_we});
        if (e_we) begin
            chk({tag, ".rd"}, {27'h0, obs_rd}, {27'h0, e_rd});
            chk({tag, ".val"}, obs_val, e_val);
        end
        $display("cyc %s valid=%0b src=%0d rd=%0d done=%0b -> we=%0b stall=%0b val=%h",
                 tag, x_valid, x_src, x_rd, done, obs_we, obs_stall, obs_val);
        @(posedge clk);
        m_byp_we = e_we;
        if (e_we) begin m_byp_rd = e_rd; m_byp_val = e_val; end
        m_fault = n_fault;
        #1;
        chk({tag, ".byp_we"}, {31'h0, byp_we}, {31'h0, m_byp_we});
        chk({tag, ".byp_rd"}, {27'h0, byp_rd}, {27'h0, m_byp_rd});
        chk({tag, ".byp_val"}, byp_val, m_byp_val);
        chk({tag, ".fault"}, {31'h0, fault}, {31'h0, m_fault});
    endtask

    task automatic set_op(input bit v, input logic [1:0] src, input logic [4:0] rd,
                          input logic [2:0] fun, input logic [1:0] addr, input bit d);
        x_valid = v; x_src = src; x_rd = rd; x_we = 1; x_fun = fun; x_addr = addr; done = d;
    endtask

    int stall_cnt, write_cnt;

    initial begin
        rst_n = 0; x_valid = 0; x_we = 0; done = 0; x_rd = 0; x_src = 0;
        x_val = 0; shf = 0; mul = 0; dm_data = 0; x_fun = 0; x_addr = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst.stall", {31'h0, stall}, 32'h0);
        chk("rst.we", {31'h0, rf_we}, 32'h0);
        chk("rst.byp_we", {31'h0, byp_we}, 32'h0);
        chk("rst.byp_val", byp_val, 32'h0);
        chk("rst.fault", {31'h0, fault}, 32'h0);
        rst_n = 1;
        @(posedge clk); #1;

        // Shifter path and bypass follow-up
        set_op(1, 2'd1, 5'd5, 3'd0, 2'd0, 0); shf = 32'h0000_00F0;
        run_cycle("shift");
        chk("shift.we_lit", {31'h0, obs_we}, 32'h1);
        chk("shift.val_lit", obs_val, 32'h0000_00F0);
        chk("shift.byp_lit", {byp_we, 26'h0, byp_rd}, {1'b1, 26'h0, 5'd5});

        // x0 suppression
        set_op(1, 2'd0, 5'd0, 3'd0, 2'd0, 0); x_val = 32'h1234;
        run_cycle("x0");
        chk("x0.byp_lit", {31'h0, byp_we}, 32'h0);

        // Load alignment with immediate completion
        dm_data = 32'h8081_7F80;
        set_op(1, 2'd3, 5'd3, 3'd0, 2'd1, 1); run_cycle("lb_a1");
        chk("lb_a1.lit", obs_val, 32'h0000_007F);
        set_op(1, 2'd3, 5'd3, 3'd0, 2'd3, 1); run_cycle("lb_a3");
        chk("lb_a3.lit", obs_val, 32'hFFFF_FF80);
        set_op(1, 2'd3, 5'd3, 3'd5, 2'd2, 1); run_cycle("lhu_a2");
        chk("lhu_a2.lit", obs_val, 32'h0000_8081);
        set_op(1, 2'd3, 5'd3, 3'd1, 2'd2, 1); run_cycle("lh_a2");
        chk("lh_a2.lit", obs_val, 32'hFFFF_8081);

        // Load wait: three stalled cycles then completion
        stall_cnt = 0; write_cnt = 0;
        set_op(1, 2'd3, 5'd7, 3'd2, 2'd0, 0); dm_data = 32'h0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) begin done = 1; dm_data = 32'hCAFE_BABE; end
            run_cycle("lwait");
            stall_cnt += int'(obs_stall); write_cnt += int'(obs_we);
        end
        chk("lwait.stall_cycles", stall_cnt, 32'd3);
        chk("lwait.writes", write_cnt, 32'd1);
        chk("lwait.val_lit", obs_val, 32'hCAFE_BABE);
        x_valid = 0; done = 0;
        run_cycle("idle");

        // Timeout: no done for the whole window
        set_op(1, 2'd3, 5'd9, 3'd2, 2'd0, 0); dm_data = 32'hDEAD_BEEF;
        for (int i = 0; i < 5; i++) run_cycle("tmo");
        chk("tmo.we_lit", {31'h0, obs_we}, 32'h1);
        chk("tmo.val_lit", obs_val, 32'h0);
        chk("tmo.fault_lit", {31'h0, fault}, 32'h1);
        x_valid = 0;
        run_cycle("tmo_after");
        chk("tmo.fault_drop", {31'h0, fault}, 32'h0);

        // Done arriving on the expiry cycle wins
        set_op(1, 2'd3, 5'd10, 3'd2, 2'd0, 0);
        for (int i = 0; i < 5; i++) begin
            if (i == 4) begin done = 1; dm_data = 32'h0000_55AA; end
            run_cycle("tmo_done");
        end
        chk("tmo_done.val_lit", obs_val, 32'h0000_55AA);
        chk("tmo_done.nofault", {31'h0, fault}, 32'h0);
        x_valid = 0; done = 0;
        run_cycle("idle2");

        // Reset in the middle of a wait
        set_op(1, 2'd3, 5'd11, 3'd2, 2'd0, 0);
        run_cycle("rstw_issue");
        run_cycle("rstw_wait");
        rst_n = 0; #1;
        chk("rstw.stall", {31'h0, stall}, 32'h0);
        chk("rstw.we", {31'h0, rf_we}, 32'h0);
        chk("rstw.byp_we", {31'h0, byp_we}, 32'h0);
        model_reset();
        x_valid = 0;
        @(posedge clk); #2;
        rst_n = 1;
        @(posedge clk); #1;
        done = 1; dm_data = 32'h1111_2222;
        run_cycle("rstw_late_done");
        chk("rstw.late_we", {31'h0, obs_we}, 32'h0);
        done = 0;

        // Random traffic against the model
        for (int n = 0; n < 1500; n++) begin
            x_valid = ($urandom_range(0, 9) < 8);
            x_we    = ($urandom_range(0, 9) < 9);
            x_rd    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            x_src   = 2'($urandom_range(0, 3));
            x_fun   = 3'($urandom_range(0, 7));
            x_addr  = 2'($urandom_range(0, 3));
            x_val   = $urandom; shf = $urandom; mul = $urandom; dm_data = $urandom;
            done    = ($urandom_range(0, 9) < 4);
            run_cycle("rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
